// File: rtl/ysyx_22050039_lsu.sv
// Load/store unit: one access at a time, EXU in, memory request/response out,
// extended load result (or error) handed to writeback.
module ysyx_22050039_lsu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic [4:0]      out_rd,
  output logic            out_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [2:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [7:0]      wmask_q, wmask_d;
  logic            wen_q, wen_d;

  logic            is_store, legal, misal;
  logic [7:0]      bmask;
  logic [XLEN-1:0] sh, ld_data;
  logic            sx;

  // request decode on the raw inputs
  always_comb begin
    is_store = in_op[3];
    legal    = is_store ? !in_op[2] : (in_op != 4'd7);
    misal    = 1'b0;
    bmask    = 8'h00;
    unique case (1'b1)
      (in_op[1:0] == 2'd0): begin
        misal = 1'b0;
        bmask = 8'h01;
      end
      (in_op[1:0] == 2'd1): begin
        misal = in_addr[0];
        bmask = 8'h03;
      end
      (in_op[1:0] == 2'd2): begin
        misal = |in_addr[1:0];
        bmask = 8'h0F;
      end
      default: begin
        misal = |in_addr[2:0];
        bmask = 8'hFF;
      end
    endcase
  end

  // response alignment and extension from the latched op
  always_comb begin
    sh      = mem_resp_data >> {off_q, 3'b000};
    sx      = ~op_q[2];
    ld_data = sh;
    unique case (1'b1)
      (op_q[1:0] == 2'd0):
        ld_data = {{(XLEN-8){sx & sh[7]}}, sh[7:0]};
      (op_q[1:0] == 2'd1):
        ld_data = {{(XLEN-16){sx & sh[15]}}, sh[15:0]};
      (op_q[1:0] == 2'd2):
        ld_data = {{(XLEN-32){sx & sh[31]}}, sh[31:0]};
      default:
        ld_data = sh;
    endcase
    if (op_q[3]) ld_data = '0;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    wen_d   = wen_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        op_d    = in_op;
        off_d   = in_addr[2:0];
        rd_d    = in_rd;
        rdata_d = '0;
        if (legal && !misal) begin
          state_d = REQ;
          err_d   = 1'b0;
          addr_d  = {in_addr[XLEN-1:3], 3'b000};
          wen_d   = is_store;
          wmask_d = is_store ? (bmask << in_addr[2:0]) : 8'h00;
          wdata_d = is_store ? (in_wdata << {in_addr[2:0], 3'b000}) : '0;
        end else begin
          state_d = DONE;
          err_d   = 1'b1;
          addr_d  = '0;
          wen_d   = 1'b0;
          wmask_d = 8'h00;
          wdata_d = '0;
        end
      end
      REQ: if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_resp_valid) begin
        state_d = DONE;
        rdata_d = ld_data;
      end
      default: if (out_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      off_q   <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      wen_q   <= wen_d;
    end
  end

  // reset holds state at IDLE, so in_ready must also see rst directly
  assign in_ready      = rst && (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_rdata     = rdata_q;
  assign out_rd        = rd_q;
  assign out_err       = err_q;
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Directed bench for ysyx_22050039_lsu: vector table plus
// stall, stray-response and mid-access reset sequences.
module tb_ysyx_22050039_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [63:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [63:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_err;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22050039_lsu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_rd(out_rd),
    .out_err(out_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] resp;
    logic        err;
    logic [63:0] maddr;
    logic [63:0] mwdata;
    logic [7:0]  wmask;
    logic        wen;
    logic [63:0] rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " out_rdata"}, out_rdata, 64'd0);
    chk({tag, " out_rd"}, 64'(out_rd), 64'd0);
    chk({tag, " out_err"}, 64'(out_err), 64'd0);
    chk({tag, " req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, " req_wen"}, 64'(mem_req_wen), 64'd0);
    chk({tag, " req_addr"}, mem_req_addr, 64'd0);
    chk({tag, " req_wdata"}, mem_req_wdata, 64'd0);
    chk({tag, " req_wmask"}, 64'(mem_req_wmask), 64'd0);
  endtask

  task automatic run(input int idx);
    vec_t v;
    logic [4:0] tag;
    bit req_seen, resp_pend, resp_on, done;
    string nm;
    v = vecs[idx];
    tag = 5'(idx + 1);
    nm = $sformatf("v%0d", idx);
    req_seen = 0; resp_pend = 0; resp_on = 0; done = 0;
    @(negedge clk);
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op = v.op;
    in_addr = v.addr;
    in_wdata = v.wdata;
    in_rd = tag;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (resp_on) begin
        mem_resp_valid = 1'b0;
        resp_on = 0;
      end
      if (resp_pend) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = v.resp;
        resp_pend = 0;
        resp_on = 1;
      end
      if (out_valid) begin
        chk({nm, " rdata"}, out_rdata, v.rdata);
        chk({nm, " err"}, 64'(out_err), 64'(v.err));
        chk({nm, " rd"}, 64'(out_rd), 64'(tag));
        chk({nm, " latency"}, 64'(n), v.err ? 64'd0 : 64'd2);
        chk({nm, " req_seen"}, 64'(req_seen), 64'(!v.err));
        done = 1;
      end else if (mem_req_valid) begin
        if (!req_seen) begin
          chk({nm, " maddr"}, mem_req_addr, v.maddr);
          chk({nm, " wmask"}, 64'(mem_req_wmask), 64'(v.wmask));
          chk({nm, " wdata"}, mem_req_wdata, v.mwdata);
          chk({nm, " wen"}, 64'(mem_req_wen), 64'(v.wen));
        end
        req_seen = 1;
        resp_pend = 1;
      end
      if (!done) @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no out_valid want out_valid", nm);
    end
    @(negedge clk);
    chk({nm, " out_valid drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{4'd2, 64'h80000004, 64'h0, 64'h80000000_00000000, 1'b0,
                 64'h80000000, 64'h0, 8'h00, 1'b0, 64'hFFFFFFFF_80000000};
    vecs[1]  = '{4'd8, 64'h80000013, 64'hAB, 64'h12345678_9ABCDEF0, 1'b0,
                 64'h80000010, 64'h00000000_AB000000, 8'h08, 1'b1, 64'h0};
    vecs[2]  = '{4'd5, 64'h80000006, 64'h0, 64'hBEEF0000_00000000, 1'b0,
                 64'h80000000, 64'h0, 8'h00, 1'b0, 64'h00000000_0000BEEF};
    vecs[3]  = '{4'd1, 64'h80000006, 64'h0, 64'hBEEF0000_00000000, 1'b0,
                 64'h80000000, 64'h0, 8'h00, 1'b0, 64'hFFFFFFFF_FFFFBEEF};
    vecs[4]  = '{4'd3, 64'h80000004, 64'h0, 64'h0, 1'b1,
                 64'h0, 64'h0, 8'h00, 1'b0, 64'h0};
    vecs[5]  = '{4'd7, 64'h80000000, 64'h0, 64'h0, 1'b1,
                 64'h0, 64'h0, 8'h00, 1'b0, 64'h0};
    vecs[6]  = '{4'd3, 64'h80000008, 64'h0, 64'h01234567_89ABCDEF, 1'b0,
                 64'h80000008, 64'h0, 8'h00, 1'b0, 64'h01234567_89ABCDEF};
    vecs[7]  = '{4'd0, 64'h80000001, 64'h0, 64'h00000000_00008000, 1'b0,
                 64'h80000000, 64'h0, 8'h00, 1'b0, 64'hFFFFFFFF_FFFFFF80};
    vecs[8]  = '{4'd4, 64'h80000001, 64'h0, 64'h00000000_00008000, 1'b0,
                 64'h80000000, 64'h0, 8'h00, 1'b0, 64'h00000000_00000080};
    vecs[9]  = '{4'd6, 64'h80000004, 64'h0, 64'h80000000_00000000, 1'b0,
                 64'h80000000, 64'h0, 8'h00, 1'b0, 64'h00000000_80000000};
    vecs[10] = '{4'd11, 64'h80000000, 64'h11223344_55667788, 64'h5, 1'b0,
                 64'h80000000, 64'h11223344_55667788, 8'hFF, 1'b1, 64'h0};
    vecs[11] = '{4'd10, 64'h80000004, 64'hDEADBEEF, 64'h0, 1'b0,
                 64'h80000000, 64'hDEADBEEF_00000000, 8'hF0, 1'b1, 64'h0};
    vecs[12] = '{4'd9, 64'h80000003, 64'h1234, 64'h0, 1'b1,
                 64'h0, 64'h0, 8'h00, 1'b0, 64'h0};
    vecs[13] = '{4'd12, 64'h80000000, 64'h0, 64'h0, 1'b1,
                 64'h0, 64'h0, 8'h00, 1'b0, 64'h0};
    vecs[14] = '{4'd9, 64'h80000006, 64'h1234, 64'h0, 1'b0,
                 64'h80000000, 64'h12340000_00000000, 8'hC0, 1'b1, 64'h0};

    rst = 1'b0;
    in_valid = 1'b0;
    in_op = '0;
    in_addr = '0;
    in_wdata = '0;
    in_rd = '0;
    out_ready = 1'b1;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;

    repeat (2) @(negedge clk);
    chk_rst("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < NV; i++) run(i);

    // request stall with a stray response, then writeback stall
    @(negedge clk);
    mem_req_ready = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_op = 4'd2;
    in_addr = 64'h80000004;
    in_rd = 5'd20;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall req_valid", 64'(mem_req_valid), 64'd1);
      chk("stall req_addr", mem_req_addr, 64'h80000000);
      chk("stall in_ready", 64'(in_ready), 64'd0);
      mem_resp_valid = (k == 1);
      mem_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    chk("stall req_valid end", 64'(mem_req_valid), 64'd1);
    chk("stall out_valid", 64'(out_valid), 64'd0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("single handshake", 64'(mem_req_valid), 64'd0);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 64'h80000000_00000000;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("hold out_valid", 64'(out_valid), 64'd1);
    chk("hold rdata", out_rdata, 64'hFFFFFFFF_80000000);
    chk("hold rd", 64'(out_rd), 64'd20);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("hold out_valid", 64'(out_valid), 64'd1);
      chk("hold rdata", out_rdata, 64'hFFFFFFFF_80000000);
      chk("hold err", 64'(out_err), 64'd0);
      chk("hold in_ready", 64'(in_ready), 64'd0);
      chk("hold req_valid", 64'(mem_req_valid), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release out_valid", 64'(out_valid), 64'd0);
    chk("release in_ready", 64'(in_ready), 64'd1);
    mem_req_ready = 1'b1;

    // reset while waiting for the response, then a late response
    in_valid = 1'b1;
    in_op = 4'd10;
    in_addr = 64'h80000004;
    in_wdata = 64'hDEADBEEF;
    in_rd = 5'd7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rw req_valid", 64'(mem_req_valid), 64'd1);
    @(negedge clk);
    chk("rw wait req_valid", 64'(mem_req_valid), 64'd0);
    chk("rw wait out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk_rst("mid reset");
    @(negedge clk);
    chk_rst("mid reset hold");
    rst = 1'b1;
    @(negedge clk);
    chk("after release in_ready", 64'(in_ready), 64'd1);
    mem_resp_valid = 1'b1;
    mem_resp_data = 64'h1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late resp out_valid", 64'(out_valid), 64'd0);
      chk("late resp in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
    end

    run(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
